// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and
// default sizing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_BURST   = 4;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Wrap-around priority search: first set bit of i_req at or after i_ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_found,
    output logic [IW-1:0]   o_index
);

    int w_pos;

    // Walk from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_pos   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NREQ) w_pos = w_pos - NREQ;
            if (i_req[w_pos]) begin
                o_found = 1'b1;
                o_index = IW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates byte requests from NREQ sources onto one UART transmitter,
// round-robin with bounded bursts per owner and a no-response timeout.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int BURST   = DEF_BURST,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ack,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t        r_state, w_next;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_grant;
    logic [CW-1:0] r_burst;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_tx_data;

    logic          w_found;
    logic [IW-1:0] w_pick;
    logic          w_keep;
    logic [IW-1:0] w_sel_idx;
    logic [IW-1:0] w_ptr_nxt;
    logic          w_select;
    logic          w_tmo;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_index (w_pick)
    );

    // r_burst==0 means no grant since reset, so there is no owner to keep.
    assign w_keep    = (r_burst != '0) && req_valid[r_grant] && (r_burst < CW'(BURST));
    assign w_sel_idx = w_keep ? r_grant : w_pick;
    assign w_ptr_nxt = (w_pick == IW'(NREQ - 1)) ? '0 : w_pick + 1'b1;
    assign w_select  = (r_state == S_IDLE) && w_found;
    assign w_tmo     = (r_timer == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_found) w_next = S_START;
            S_START:     w_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (tx_busy)    w_next = S_WAIT_DONE;
                else if (w_tmo) w_next = S_IDLE;
            end
            S_WAIT_DONE: if (!tx_busy) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_grant   <= '0;
            r_burst   <= '0;
            r_timer   <= '0;
            r_tx_data <= '0;
        end else begin
            if (w_select) begin
                r_tx_data <= req_data[{w_sel_idx, 3'b000} +: 8];
                r_grant   <= w_sel_idx;
                if (w_keep) begin
                    r_burst <= r_burst + 1'b1;
                end else begin
                    r_burst <= CW'(1);
                    r_ptr   <= w_ptr_nxt;
                end
            end
            if (r_state == S_START)
                r_timer <= '0;
            else if (r_state == S_WAIT_ACK && !tx_busy && !w_tmo)
                r_timer <= r_timer + 1'b1;
        end
    end

    always_comb begin
        tx_start    = (r_state == S_START);
        req_ack     = '0;
        if (r_state == S_START) req_ack[r_grant] = 1'b1;
        busy        = (r_state != S_IDLE);
        err_timeout = (r_state == S_WAIT_ACK) && !tx_busy && w_tmo;
    end

    assign tx_data  = r_tx_data;
    assign grant_id = r_grant;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: two instances (BURST=4 and BURST=1), requester queues,
// a simple transmitter model and a transaction-level grant predictor.
module tb_uart_tx_arb;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rv      [2];
    logic [31:0] rd      [2];
    logic        tb_busy [2];
    logic [3:0]  ack     [2];
    logic [7:0]  txd     [2];
    logic        txs     [2];
    logic [1:0]  gid     [2];
    logic        bsy     [2];
    logic        err     [2];

    always #5 clk = ~clk;

    uart_tx_arb #(.NREQ(4), .BURST(4), .TIMEOUT(TMO)) u_b4 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_data(rd[0]), .req_ack(ack[0]),
        .tx_data(txd[0]), .tx_start(txs[0]), .tx_busy(tb_busy[0]), .grant_id(gid[0]),
        .busy(bsy[0]), .err_timeout(err[0])
    );

    uart_tx_arb #(.NREQ(4), .BURST(1), .TIMEOUT(TMO)) u_b1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_data(rd[1]), .req_ack(ack[1]),
        .tx_data(txd[1]), .tx_start(txs[1]), .tx_busy(tb_busy[1]), .grant_id(gid[1]),
        .busy(bsy[1]), .err_timeout(err[1])
    );

    int total = 0;
    int bad   = 0;
    int act   = 0;

    logic [7:0] bytes [4][8];
    int         hd [4];
    int         tl [4];

    int m_last, m_cnt, m_ptr;
    logic [3:0]  last_rv;
    logic [31:0] last_rd;
    logic [7:0]  prev_d;
    int started, since, silent, tdly, thold, n_err, err_since;
    int glog [$];
    int dlog [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    // Spec-level arbitration rule: keep owner while valid and under burst, else round robin.
    task automatic predict(input logic [3:0] v, output int g);
        int bl;
        bl = (act == 0) ? 4 : 1;
        g  = -1;
        if (m_last >= 0 && v[m_last] && m_cnt < bl) begin
            m_cnt++;
            g = m_last;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (g < 0 && v[idx]) begin
                    g = idx; m_cnt = 1; m_ptr = (idx + 1) % 4; m_last = idx;
                end
            end
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            rv[act][i]         = (hd[i] < tl[i]);
            rd[act][8*i +: 8]  = (hd[i] < tl[i]) ? bytes[i][hd[i]] : 8'h00;
        end
        last_rv = rv[act];
        last_rd = rd[act];
    endtask

    task automatic push(input int r, input logic [7:0] b);
        bytes[r][tl[r]] = b;
        tl[r]++;
    endtask

    task automatic model_reset();
        m_last = -1; m_cnt = 0; m_ptr = 0;
        started = 0; since = 0; tdly = 0; thold = 0;
        prev_d = 8'h00;
    endtask

    task automatic cycle();
        logic [3:0] a;
        logic       s, e;
        logic [7:0] d;
        logic [1:0] g;
        int         eg;
        @(negedge clk);
        a = ack[act]; s = txs[act]; e = err[act]; d = txd[act]; g = gid[act];
        chk("ack_onehot0", 32'($onehot0(a)), 32'd1);
        chk("other_inst_busy", 32'(bsy[1-act]), 32'd0);
        if (s) begin
            chk("start_while_txbusy", 32'(tb_busy[act]), 32'd0);
            predict(last_rv, eg);
            if (eg < 0) begin
                chk("spurious_start", 32'd1, 32'd0);
            end else begin
                chk("grant_id", 32'(g), 32'(eg));
                chk("tx_data", 32'(d), 32'(last_rd[8*eg +: 8]));
                chk("req_ack", 32'(a), 32'(1 << eg));
            end
            glog.push_back(int'(g));
            dlog.push_back(int'(d));
            since = 0; started = 1;
        end else begin
            chk("ack_without_start", 32'(a), 32'd0);
            chk("tx_data_stable", 32'(d), 32'(prev_d));
            if (started != 0) since++;
        end
        chk("err_timeout", 32'(e), 32'((silent != 0) && (started != 0) && (since == TMO + 1)));
        if (e) begin
            n_err++; err_since = since; started = 0;
        end
        for (int i = 0; i < 4; i++) if (a[i]) hd[i]++;
        if (tdly > 0) begin
            tdly--;
            if (tdly == 0) begin tb_busy[act] = 1'b1; thold = 10; end
        end else if (thold > 0) begin
            thold--;
            if (thold == 0) tb_busy[act] = 1'b0;
        end
        if (s && silent == 0) tdly = 2;
        prev_d = d;
        drive_reqs();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tb_busy[0] = 1'b0; tb_busy[1] = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            chk({tag, "_tx_data"},  32'(txd[n]), 32'd0);
            chk({tag, "_grant_id"}, 32'(gid[n]), 32'd0);
            chk({tag, "_busy"},     32'(bsy[n]), 32'd0);
            chk({tag, "_req_ack"},  32'(ack[n]), 32'd0);
            chk({tag, "_tx_start"}, 32'(txs[n]), 32'd0);
            chk({tag, "_err"},      32'(err[n]), 32'd0);
        end
        rst = 1'b0;
        model_reset();
        drive_reqs();
    endtask

    task automatic run_until_done(input string tag, input int maxc);
        int c;
        logic done;
        c = 0; done = 1'b0;
        while (!done && c < maxc) begin
            cycle();
            c++;
            if (n_err > 0) silent = 0;
            done = !bsy[act] && !tb_busy[act] && tdly == 0 && thold == 0;
            for (int i = 0; i < 4; i++) if (hd[i] < tl[i]) done = 1'b0;
        end
        if (!done) chk({tag, "_wait_expired"}, 32'd1, 32'd0);
    endtask

    task automatic set_act(input int a);
        for (int i = 0; i < 4; i++) begin hd[i] = 0; tl[i] = 0; end
        rv[act] = 4'h0; rd[act] = 32'h0;
        act = a;
        model_reset();
        drive_reqs();
        glog.delete(); dlog.delete();
    endtask

    initial begin
        int cnt;
        for (int n = 0; n < 2; n++) begin
            rv[n] = 4'h0; rd[n] = 32'h0; tb_busy[n] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin hd[i] = 0; tl[i] = 0; end
        silent = 0; n_err = 0; err_since = 0;
        last_rv = 4'h0; last_rd = 32'h0;
        model_reset();

        // Reset state on both instances.
        do_reset("rst0");

        // Single byte from requester 0.
        set_act(0);
        push(0, 8'h55);
        run_until_done("single", 200);
        chk("single_n", 32'(glog.size()), 32'd1);
        if (glog.size() == 1) begin
            chk("single_gid", 32'(glog[0]), 32'd0);
            chk("single_byte", 32'(dlog[0]), 32'h55);
        end

        // Fairness with BURST=1: order 0,1,2,3,0.
        set_act(1);
        push(0, 8'hA0); push(0, 8'hA1); push(1, 8'hB0); push(2, 8'hC0); push(3, 8'hD0);
        run_until_done("fair", 400);
        begin
            int ef [5] = '{0, 1, 2, 3, 0};
            int eb [5] = '{'hA0, 'hB0, 'hC0, 'hD0, 'hA1};
            chk("fair_n", 32'(glog.size()), 32'd5);
            if (glog.size() == 5)
                for (int i = 0; i < 5; i++) begin
                    chk("fair_order", 32'(glog[i]), 32'(ef[i]));
                    chk("fair_byte", 32'(dlog[i]), 32'(eb[i]));
                end
        end

        // Burst with BURST=4: requester 2 owns the line first, requester 0 joins.
        set_act(0);
        do_reset("rst1");
        for (int i = 0; i < 5; i++) push(2, 8'(8'h20 + i));
        drive_reqs();
        cnt = 0;
        while (glog.size() < 1 && cnt < 50) begin cycle(); cnt++; end
        if (glog.size() < 1) chk("burst_first_wait_expired", 32'd1, 32'd0);
        push(0, 8'h01);
        run_until_done("burst", 600);
        begin
            int eo [6] = '{2, 2, 2, 2, 0, 2};
            chk("burst_n", 32'(glog.size()), 32'd6);
            if (glog.size() == 6)
                for (int i = 0; i < 6; i++) chk("burst_order", 32'(glog[i]), 32'(eo[i]));
        end

        // Timeout: first frame never gets tx_busy, second one is answered.
        glog.delete(); dlog.delete();
        silent = 1; n_err = 0;
        push(1, 8'h77); push(3, 8'h33);
        drive_reqs();
        run_until_done("tmo", 400);
        chk("tmo_n_err", 32'(n_err), 32'd1);
        chk("tmo_latency", 32'(err_since), 32'd16);
        chk("tmo_n", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("tmo_g0", 32'(glog[0]), 32'd3);
            chk("tmo_g1", 32'(glog[1]), 32'd1);
            chk("tmo_b1", 32'(dlog[1]), 32'h77);
        end

        // Reset while in WAIT_DONE, then ptr restarts from 0.
        glog.delete(); dlog.delete();
        silent = 0;
        push(1, 8'h11); push(1, 8'h12); push(3, 8'h33);
        drive_reqs();
        cnt = 0;
        while (!(bsy[act] && tb_busy[act]) && cnt < 60) begin cycle(); cnt++; end
        if (!(bsy[act] && tb_busy[act])) chk("wdone_wait_expired", 32'd1, 32'd0);
        chk("pre_rst_byte", 32'(dlog.size() > 0 ? dlog[0] : 0), 32'h11);
        glog.delete(); dlog.delete();
        do_reset("rst2");
        run_until_done("post_rst", 400);
        chk("post_rst_n", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("post_rst_g0", 32'(glog[0]), 32'd1);
            chk("post_rst_b0", 32'(dlog[0]), 32'h12);
            chk("post_rst_g1", 32'(glog[1]), 32'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=running want=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter BURST, default 4: maximum consecutive bytes granted to one requester.
REQ-003 SHALL have parameter TIMEOUT, default 15: clk cycles to wait for tx_busy after tx_start.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester byte pending; held with data until acked.
REQ-007 SHALL have port req_data  input  8*NREQ  requester i byte on bits [8i+7:8i].
REQ-008 SHALL have port req_ack  output  NREQ  one-cycle pulse: byte of requester i taken.
REQ-009 SHALL have port tx_data  output  8  byte presented to the shared UART transmitter.
REQ-010 SHALL have port tx_start  output  1  one-cycle pulse that launches a frame.
REQ-011 SHALL have port tx_busy  input  1  transmitter frame in progress.
REQ-012 SHALL have port grant_id  output  clog2(NREQ)  index of current or last granted requester.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port err_timeout  output  1  one-cycle pulse on transmitter no-response.

Function
REQ-015 SHALL implement states IDLE, START, WAIT_ACK, WAIT_DONE.
REQ-016 IDLE: with any req_valid set, SHALL select one requester, register tx_data from its req_data and grant_id, pulse its req_ack next cycle, and enter START.
REQ-017 Selection SHALL be round-robin: search begins at ptr, wrapping from NREQ-1 to 0; ptr becomes grant_id+1 (mod NREQ) whenever the grant rotates.
REQ-018 Burst: if the previous grant's requester still has req_valid and burst_cnt < BURST, it SHALL be re-selected ahead of round-robin; burst_cnt increments per grant.
REQ-019 When burst_cnt reaches BURST or the owner drops req_valid, burst_cnt SHALL reset to 1 on the next grant and round-robin SHALL apply (a sole active requester is re-granted).
REQ-020 START: tx_start SHALL be high exactly one cycle, tx_data stable; next state WAIT_ACK, timer cleared.
REQ-021 WAIT_ACK: tx_busy=1 SHALL move to WAIT_DONE; otherwise timer increments; timer==TIMEOUT SHALL pulse err_timeout and return to IDLE (byte dropped).
REQ-022 WAIT_DONE: tx_busy=0 SHALL return to IDLE; no new tx_start while tx_busy=1.
REQ-023 Minimum byte-to-byte spacing: IDLE->START->WAIT_ACK->WAIT_DONE->IDLE; a new selection occurs the cycle IDLE is re-entered.
REQ-024 tx_data SHALL change only on a selection in IDLE.
REQ-025 req_ack SHALL be one-hot or zero; at most one ack per grant.
REQ-026 req_valid changes outside IDLE SHALL have no effect until the next IDLE.

Reset
REQ-027 rst SHALL take effect on the clock edge it is sampled high, overriding all other events.
REQ-028 On reset: state IDLE, ptr 0, burst_cnt 0, timer 0, tx_data 0, tx_start 0, req_ack 0, grant_id 0, busy 0, err_timeout 0.
REQ-029 Reset mid-frame SHALL abort without ack or tx_start; the transmitter is reset by the same rst.

Structure
REQ-030 State encoding, default NREQ/BURST/TIMEOUT constants SHALL live in shared package uart_pkg.
REQ-031 A combinational sub-module rr_pick (inputs req vector, ptr; outputs found, index) SHALL implement the wrap-around priority search.

Verification
REQ-032 Single: req_valid=0001, data 0x55; tx_busy rises 2 cycles after tx_start, held 10 -> one tx_start, tx_data=0x55, req_ack=0001 once, grant_id=0.
REQ-033 Fairness: all four valid, BURST=1 -> grant order 0,1,2,3,0, one ack each.
REQ-034 Burst: req 2 always valid with req 0 valid, BURST=4 -> four grants to 2, then 0, then 2.
REQ-035 Timeout: tx_busy held 0 after tx_start -> err_timeout pulse 15 cycles after WAIT_ACK entry, state IDLE, next grant proceeds.
REQ-036 Reset in WAIT_DONE -> all outputs reset values next cycle, no ack/start; first grant after reset goes to lowest valid index from ptr 0.
